// File: rtl/multicycle_control_if.sv
// Bundles the instruction fields, memory handshake and datapath
// controls that the multicycle control FSM exchanges with its datapath.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [3:0]  state;
    logic        trap;
    logic [31:0] retired;

    // Controller side.
    modport slave (
        input  opcode, funct3, funct7_b5, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op,
               state, trap, retired
    );

    // Datapath side.
    modport master (
        output opcode, funct3, funct7_b5, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op,
               state, trap, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV-subset control FSM: fetch/decode/execute sequencing for
// R-type add/sub/and/or, ld, sd and beq, with a sticky illegal-instruction
// trap and a retired-instruction counter.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_BRANCH = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_LD  = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_r;
    state_t      next_state_s;
    logic        trap_r;
    logic [31:0] retired_r;
    logic        retire_s;
    logic        rtype_ok_s;
    logic [3:0]  rtype_op_s;

    logic        pc_write_s, ir_write_s, iord_s, mem_read_s, mem_write_s;
    logic        reg_write_s, mem_to_reg_s, pc_src_s, alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [3:0]  alu_op_s;

    // R-type funct3/funct7 decode into an ALU operation and a legality flag.
    always_comb begin
        rtype_ok_s = 1'b1;
        rtype_op_s = ALU_ADD;
        case (bus.funct3)
            3'b000:  rtype_op_s = bus.funct7_b5 ? ALU_SUB : ALU_ADD;
            3'b111:  rtype_op_s = ALU_AND;
            3'b110:  rtype_op_s = ALU_OR;
            default: begin
                rtype_ok_s = 1'b0;
                rtype_op_s = 4'b0000;
            end
        endcase
    end

    // Next-state selection; undefined state codes fall into TRAP.
    always_comb begin
        next_state_s = S_TRAP;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready) next_state_s = S_DECODE;
                else               next_state_s = S_FETCH;
            end
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE)
                    next_state_s = S_EXEC_R;
                else if ((bus.opcode == OP_LOAD) && (bus.funct3 == 3'b011))
                    next_state_s = S_ADDR;
                else if ((bus.opcode == OP_STORE) && (bus.funct3 == 3'b011))
                    next_state_s = S_ADDR;
                else if ((bus.opcode == OP_BRANCH) && (bus.funct3 == 3'b000))
                    next_state_s = S_BRANCH;
                else
                    next_state_s = S_TRAP;
            end
            S_EXEC_R: begin
                if (rtype_ok_s) next_state_s = S_WB_R;
                else            next_state_s = S_TRAP;
            end
            S_ADDR: begin
                if (bus.opcode == OP_LOAD) next_state_s = S_MEM_RD;
                else                       next_state_s = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) next_state_s = S_WB_LD;
                else               next_state_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) next_state_s = S_FETCH;
                else               next_state_s = S_MEM_WR;
            end
            S_WB_R:   next_state_s = S_FETCH;
            S_WB_LD:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_TRAP;
        endcase
    end

    // An instruction completes on the edge that leaves its final state.
    assign retire_s = (state_r == S_WB_R) || (state_r == S_WB_LD) ||
                      (state_r == S_BRANCH) ||
                      ((state_r == S_MEM_WR) && bus.mem_ready);

    // State register, sticky trap flag and wrapping retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_FETCH;
            trap_r    <= 1'b0;
            retired_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == S_TRAP) trap_r <= 1'b1;
            else                        trap_r <= trap_r;
            if (retire_s) retired_r <= retired_r + 32'd1;
            else          retired_r <= retired_r;
        end
    end

    // Datapath controls decoded from the state register. Reset also gates
    // them so nothing is requested while held in reset (the state register
    // already sits at FETCH) and an in-flight access aborts at once.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        pc_src_s     = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 4'b0000;
        if (reset == 1'b0) begin
            mem_read_s = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = 2'b01;
                    alu_op_s    = ALU_ADD;
                    ir_write_s  = bus.mem_ready;
                    pc_write_s  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b_s = 2'b10;
                    alu_op_s    = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = rtype_op_s;
                end
                S_ADDR: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                    alu_op_s    = ALU_ADD;
                end
                S_BRANCH: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = ALU_SUB;
                    pc_src_s    = 1'b1;
                    pc_write_s  = bus.zero;
                end
                S_MEM_RD: begin
                    iord_s     = 1'b1;
                    mem_read_s = 1'b1;
                end
                S_MEM_WR: begin
                    iord_s      = 1'b1;
                    mem_write_s = 1'b1;
                end
                S_WB_R: begin
                    reg_write_s = 1'b1;
                end
                S_WB_LD: begin
                    reg_write_s  = 1'b1;
                    mem_to_reg_s = 1'b1;
                end
                default: begin
                    mem_read_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_write   = pc_write_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.iord       = iord_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.state      = state_r;
    assign bus.trap       = trap_r;
    assign bus.retired    = retired_r;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-computed state and control vectors.
module tb_multicycle_control;
    logic clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
    //  pc_src, alu_src_a, alu_src_b[1:0], alu_op[3:0]}
    logic [14:0] ctl_vec;
    assign ctl_vec = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read,
                      bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.pc_src,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op};

    localparam logic [14:0] C_F_RDY  = 15'b11010000_0_01_0010;
    localparam logic [14:0] C_F_WAIT = 15'b00010000_0_01_0010;
    localparam logic [14:0] C_DEC    = 15'b00000000_0_10_0010;
    localparam logic [14:0] C_EX_ADD = 15'b00000000_1_00_0010;
    localparam logic [14:0] C_EX_SUB = 15'b00000000_1_00_0110;
    localparam logic [14:0] C_EX_AND = 15'b00000000_1_00_0000;
    localparam logic [14:0] C_EX_OR  = 15'b00000000_1_00_0001;
    localparam logic [14:0] C_EX_BAD = 15'b00000000_1_00_0000;
    localparam logic [14:0] C_WB_R   = 15'b00000100_0_00_0000;
    localparam logic [14:0] C_WB_LD  = 15'b00000110_0_00_0000;
    localparam logic [14:0] C_ADDR   = 15'b00000000_1_10_0010;
    localparam logic [14:0] C_MEM_RD = 15'b00110000_0_00_0000;
    localparam logic [14:0] C_MEM_WR = 15'b00101000_0_00_0000;
    localparam logic [14:0] C_BR_T   = 15'b10000001_1_00_0110;
    localparam logic [14:0] C_BR_N   = 15'b00000001_1_00_0110;
    localparam logic [14:0] C_NONE   = 15'b00000000_0_00_0000;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7_b5 = f7;
    endtask

    // One clock cycle: drive mem_ready, check state and controls, advance.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [14:0] ctl);
        bus.mem_ready = rdy;
        #1;
        chk({tag, ".state"}, {28'd0, bus.state}, {28'd0, st});
        chk({tag, ".ctl"}, {17'd0, ctl_vec}, {17'd0, ctl});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // Held in reset: everything quiet even with mem_ready high.
        @(posedge clk);
        #1;
        chk("rst.state", {28'd0, bus.state}, 32'd0);
        chk("rst.ctl", {17'd0, ctl_vec}, 32'd0);
        chk("rst.retired", bus.retired, 32'd0);
        chk("rst.trap", {31'd0, bus.trap}, 32'd0);
        reset = 1'b1;
        #1;
        chk("first_fetch.mem_read", {31'd0, bus.mem_read}, 32'd1);

        // add x3,x1,x2
        cyc("add.f", 1'b1, 4'd0, C_F_RDY);
        cyc("add.d", 1'b1, 4'd1, C_DEC);
        cyc("add.ex", 1'b1, 4'd2, C_EX_ADD);
        chk("add.retired_before", bus.retired, 32'd0);
        cyc("add.wb", 1'b1, 4'd7, C_WB_R);
        chk("add.retired", bus.retired, 32'd1);

        // ld with two wait cycles in MEM_RD
        set_instr(7'b0000011, 3'b011, 1'b0);
        cyc("ld.f", 1'b1, 4'd0, C_F_RDY);
        cyc("ld.d", 1'b1, 4'd1, C_DEC);
        cyc("ld.a", 1'b1, 4'd3, C_ADDR);
        cyc("ld.m0", 1'b0, 4'd5, C_MEM_RD);
        cyc("ld.m1", 1'b0, 4'd5, C_MEM_RD);
        cyc("ld.m2", 1'b1, 4'd5, C_MEM_RD);
        cyc("ld.wb", 1'b1, 4'd8, C_WB_LD);
        chk("ld.retired", bus.retired, 32'd2);

        // sd with one fetch wait cycle
        set_instr(7'b0100011, 3'b011, 1'b0);
        cyc("sd.fw", 1'b0, 4'd0, C_F_WAIT);
        cyc("sd.f", 1'b1, 4'd0, C_F_RDY);
        cyc("sd.d", 1'b1, 4'd1, C_DEC);
        cyc("sd.a", 1'b1, 4'd3, C_ADDR);
        cyc("sd.m", 1'b1, 4'd6, C_MEM_WR);
        chk("sd.retired", bus.retired, 32'd3);

        // beq taken, then not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        bus.zero = 1'b1;
        cyc("beq1.f", 1'b1, 4'd0, C_F_RDY);
        cyc("beq1.d", 1'b1, 4'd1, C_DEC);
        cyc("beq1.b", 1'b1, 4'd4, C_BR_T);
        bus.zero = 1'b0;
        cyc("beq2.f", 1'b1, 4'd0, C_F_RDY);
        cyc("beq2.d", 1'b1, 4'd1, C_DEC);
        cyc("beq2.b", 1'b1, 4'd4, C_BR_N);
        chk("beq.retired", bus.retired, 32'd5);

        // sub, and, or
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("sub.f", 1'b1, 4'd0, C_F_RDY);
        cyc("sub.d", 1'b1, 4'd1, C_DEC);
        cyc("sub.ex", 1'b1, 4'd2, C_EX_SUB);
        cyc("sub.wb", 1'b1, 4'd7, C_WB_R);
        set_instr(7'b0110011, 3'b111, 1'b0);
        cyc("and.f", 1'b1, 4'd0, C_F_RDY);
        cyc("and.d", 1'b1, 4'd1, C_DEC);
        cyc("and.ex", 1'b1, 4'd2, C_EX_AND);
        cyc("and.wb", 1'b1, 4'd7, C_WB_R);
        set_instr(7'b0110011, 3'b110, 1'b0);
        cyc("or.f", 1'b1, 4'd0, C_F_RDY);
        cyc("or.d", 1'b1, 4'd1, C_DEC);
        cyc("or.ex", 1'b1, 4'd2, C_EX_OR);
        cyc("or.wb", 1'b1, 4'd7, C_WB_R);
        chk("alu.retired", bus.retired, 32'd8);

        // Retire counter wraps through zero on an sd.
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        set_instr(7'b0100011, 3'b011, 1'b0);
        cyc("wrap.f", 1'b1, 4'd0, C_F_RDY);
        chk("wrap.preload", bus.retired, 32'hFFFF_FFFF);
        cyc("wrap.d", 1'b1, 4'd1, C_DEC);
        cyc("wrap.a", 1'b1, 4'd3, C_ADDR);
        cyc("wrap.m", 1'b1, 4'd6, C_MEM_WR);
        chk("wrap.retired", bus.retired, 32'd0);

        // Reset pulsed during a stalled store.
        cyc("wrap2.f", 1'b1, 4'd0, C_F_RDY);
        cyc("wrap2.d", 1'b1, 4'd1, C_DEC);
        cyc("rst_mw.a", 1'b1, 4'd3, C_ADDR);
        chk("rst_mw.retired_pre", bus.retired, 32'd0);
        cyc("rst_mw.m", 1'b0, 4'd6, C_MEM_WR);
        bus.mem_ready = 1'b0;
        #1;
        chk("rst_mw.mem_write_on", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mw.mem_write_off", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_mw.ctl_off", {17'd0, ctl_vec}, 32'd0);
        chk("rst_mw.state_async", {28'd0, bus.state}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mw.state_rel", {28'd0, bus.state}, 32'd0);
        chk("rst_mw.retired_rel", bus.retired, 32'd0);
        chk("rst_mw.mem_read_rel", {31'd0, bus.mem_read}, 32'd1);

        // Illegal opcode traps from DECODE and stays there.
        set_instr(7'b1111111, 3'b000, 1'b0);
        bus.zero = 1'b1;
        cyc("ill.f", 1'b1, 4'd0, C_F_RDY);
        chk("ill.trap_pre", {31'd0, bus.trap}, 32'd0);
        cyc("ill.d", 1'b1, 4'd1, C_DEC);
        for (int i = 0; i < 10; i++) begin
            chk("ill.trap", {31'd0, bus.trap}, 32'd1);
            cyc("ill.hold", 1'b1, 4'd9, C_NONE);
        end
        chk("ill.retired", bus.retired, 32'd0);

        // Reset clears the trap; undecoded R-type funct3 traps from EXEC_R.
        do_reset();
        chk("trap_clr", {31'd0, bus.trap}, 32'd0);
        set_instr(7'b0110011, 3'b001, 1'b1);
        cyc("bad.f", 1'b1, 4'd0, C_F_RDY);
        cyc("bad.d", 1'b1, 4'd1, C_DEC);
        cyc("bad.ex", 1'b1, 4'd2, C_EX_BAD);
        for (int i = 0; i < 10; i++) begin
            chk("bad.trap", {31'd0, bus.trap}, 32'd1);
            cyc("bad.hold", 1'b1, 4'd9, C_NONE);
        end
        chk("bad.retired", bus.retired, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 opcode  in  7  instruction[6:0] from the instruction register (IR).
REQ-005 funct3  in  3  instruction[14:12] from the IR.
REQ-006 funct7_b5  in  1  instruction[30] from the IR.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completion strobe, valid one cycle.
REQ-009 pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src  out  1 each  datapath strobes and mux selects.
REQ-010 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-011 alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = immediate.
REQ-012 alu_op  out  4  ALU operation: ADD 0010, SUB 0110, AND 0000, OR 0001.
REQ-013 state  out  4  current state encoding.
REQ-014 trap  out  1  illegal instruction seen; sticky.
REQ-015 retired  out  32  count of completed instructions.

Function
REQ-016 States and encodings SHALL be FETCH 0, DECODE 1, EXEC_R 2, ADDR 3, BRANCH 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_LD 8, TRAP 9; codes 10-15 SHALL go to TRAP on the next edge.
REQ-017 FETCH SHALL drive: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
- Hold FETCH while mem_ready=0.
- In the mem_ready=1 cycle only, also assert ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
REQ-018 DECODE SHALL drive alu_src_a=0, alu_src_b=10, alu_op=ADD (branch target into ALUOut), then select the next state:
- 0110011 -> EXEC_R.
- 0000011 with funct3=011 -> ADDR.
- 0100011 with funct3=011 -> ADDR.
- 1100011 with funct3=000 -> BRANCH.
- Any other opcode/funct3 -> TRAP.
REQ-019 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, with alu_op decoded as:
- funct3 000, funct7_b5=0 -> ADD.
- funct3 000, funct7_b5=1 -> SUB.
- funct3 111 -> AND.
- funct3 110 -> OR.
- Decoded combination -> WB_R; any other funct3 -> TRAP, with no reg_write.
REQ-020 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=ADD, then go to MEM_RD if opcode=0000011, else MEM_WR.
REQ-021 MEM_RD and MEM_WR SHALL drive iord=1 with mem_read=1 or mem_write=1 respectively, and hold the state until mem_ready=1.
- MEM_RD -> WB_LD.
- MEM_WR -> FETCH.
REQ-022 WB_R SHALL drive reg_write=1, mem_to_reg=0; WB_LD SHALL drive reg_write=1, mem_to_reg=1; both go to FETCH after one cycle.
REQ-023 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=1, pc_write=zero (combinational), then go to FETCH.
REQ-024 TRAP SHALL set trap=1, drive all strobes to 0, and remain in TRAP until reset.
REQ-025 Any output not named for a state SHALL be 0 in that state.
REQ-026 retired SHALL increment by 1 (modulo 2^32, wrapping 0xFFFFFFFF -> 0) on the clock edge that leaves each of these:
- WB_R.
- WB_LD.
- BRANCH.
- MEM_WR (with mem_ready=1).
REQ-027 Latencies, assuming zero memory wait, SHALL be:
- R-type 4 cycles.
- ld 5 cycles.
- sd 4 cycles.
- beq 3 cycles.
- Each cycle with mem_ready=0 adds one cycle.
REQ-028 mem_ready asserted outside FETCH, MEM_RD or MEM_WR SHALL be ignored.

Reset
REQ-029 While reset=0 the block SHALL force state=FETCH, retired=0, trap=0, and all strobe and select outputs to 0, including mem_read.
REQ-030 Reset asserted mid-transaction SHALL abort immediately, asynchronously; no pending pc_write, reg_write or mem_write may be issued.
REQ-031 The first FETCH request SHALL appear in the first cycle after reset deasserts.

Verification
REQ-032 add x3,x1,x2 with mem_ready=1 every cycle -> states 0,1,2,7,0; EXEC_R alu_op=0010; reg_write=1 only in WB_R; retired 0->1.
REQ-033 ld with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with mem_read=1, iord=1; WB_LD mem_to_reg=1; total 7 cycles.
REQ-034 beq twice, zero=1 then zero=0 -> pc_write=1, pc_src=1 in the first BRANCH; pc_write=0 in the second; retired +2.
REQ-035 opcode 1111111, then sub with funct3=001 after a reset -> state 9, trap=1, all strobes 0 held for 10 cycles; the second case also reaches TRAP from EXEC_R.
REQ-036 retired preloaded to 0xFFFFFFFF by running that many instructions, or forced via a bench force, then an sd -> retired=0x00000000.
REQ-037 reset pulsed low during MEM_WR with mem_ready=0 -> mem_write drops to 0 immediately; state=0 and retired=0 at release.
